dft_stimulus_gen: RTL and testbench
===================================

# dft_stimulus_gen

Sequential, parametrised test-vector source for the DFT datapath. On a start request it streams one frame of N_POINTS IEEE-754 single-precision samples built from a selectable pattern and a programmable integer amplitude. Samples leave over a valid/ready stream with index and last-beat tags. It sits between the bench/control logic and the DFT input buffer, replacing fixed per-selector constant tables.

## Interface
- N_POINTS, 16: samples per frame; power of two, 2..1024.
- IW, 8: width of amplitude `cfg_value`; 1..24, so every value converts to FP32 exactly.
- IDXW, $clog2(N_POINTS): width of `out_index`.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high (fixed); all state and outputs clear immediately.
- start  in  1  frame request, sampled only in IDLE.
- cfg_mode  in  2  pattern: 0 CONST, 1 RAMP, 2 ALT, 3 IMPULSE; latched on accepted start.
- cfg_value  in  IW  unsigned amplitude/offset C; latched on accepted start.
- out_data  out  32  FP32 sample.
- out_valid  out  1  sample present.
- out_ready  in  1  downstream accepts; a beat transfers when valid and ready are both high.
- out_index  out  IDXW  sample index i within the frame.
- out_last  out  1  high with i = N_POINTS-1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last beat transfers.

## Operation
- FSM with two states:
  - IDLE: accepts `start`, then loads mode and C, sets i=0, and moves to RUN.
  - RUN: presents sample i. On each transfer, i increments. A transfer at i = N_POINTS-1 returns the FSM to IDLE and sets `done` for the next cycle.
- `start` in RUN is ignored; it is not queued.
- Integer sample v_i, computed in IW bits:
  - CONST: v=C.
  - RAMP: v=(C+i) mod 2^IW, wrapping silently.
  - ALT: v=C, negative on odd i.
  - IMPULSE: v=C at i=0, else 0.
- FP32 conversion:
  - v=0 gives 0x00000000.
  - Otherwise p = MSB position of v; exponent = 127+p; mantissa = the bits of v below the MSB, left-aligned in 23 bits.
  - Sign bit is set only for ALT odd samples with v≠0; -0 is never produced.
- Under backpressure, `out_data`, `out_index`, and `out_last` hold stable while valid && !ready.
- Reset mid-frame aborts the frame. No `done` is issued, and the next frame starts only on a fresh `start`.

## Timing
- All outputs are registered. Reset value of every output is 0.
- An accepted `start` at cycle t gives `out_valid`=1 with i=0 at t+1.
- With `out_ready` held high, one sample is produced per cycle, so a frame takes N_POINTS cycles.
- A last-beat transfer at cycle t gives `out_valid`=0, `busy`=0, and `done`=1 at t+1.
- FSM is IDLE during the `done` cycle, so `start` there is accepted. The next frame's first valid then appears at t+2, leaving one bubble cycle between frames.
- `busy` rises at t+1 after an accepted start and falls with the `done` cycle.
- Conversion is combinational from the registered v_i/sign feeding the output register. There is no extra pipeline stage.

## Structure
- Package `dft_stim_pkg` holds:
  - mode enum: MODE_CONST, MODE_RAMP, MODE_ALT, MODE_IMPULSE;
  - FSM state enum: ST_IDLE, ST_RUN;
  - constants FP32_ZERO=32'h0000_0000 and FP32_BIAS=127.
- One sub-module, `int_to_fp32`: combinational, parameter IW, inputs unsigned value and sign, output 32-bit FP32; built on a priority encoder and left shift.
- Top holds the FSM, index counter, pattern mux, and output registers.

## Test plan
- RAMP, C=0, N=16, ready=1: beats are 0x00000000, 0x3F800000, 0x40000000, 0x40400000 … 0x41700000; `out_last` only on index 15; `done` one cycle later.
- ALT, C=6: beats alternate 0x40C00000, 0xC0C00000 for 16 beats. ALT with C=0: all beats 0x00000000, never 0x80000000.
- IMPULSE, C=1: index 0 is 0x3F800000, indices 1..15 are 0x00000000. CONST, C=255, IW=8: every beat is 0x437F0000.
- Backpressure: RAMP with C=0, `out_ready` low for 3 cycles while index 5 is presented. Data stays 0x40A00000 with index 5 throughout; index 6 (0x40C00000) follows the release; frame length still 16 beats.
- Wrap and overlap: with IW=4, RAMP, C=15, index 0 is 0x41700000 and index 1 is 0x00000000. `start` pulsed mid-frame is ignored. `start` in the `done` cycle yields the next first beat two cycles after the previous last beat.
- Reset: assert `rst` at index 7. Outputs drop to 0 asynchronously, with no `done`. After release, a new `start` begins at index 0.

Source files
------------

// File: rtl/dft_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dft_stim_pkg
// Description : Shared types and constants for the DFT stimulus generator:
//               pattern-select encoding, FSM state encoding and FP32
//               constants used by the integer-to-float converter.
// Revision    : 1.0 - initial release
// ============================================================================
package dft_stim_pkg;

    // Pattern selector, encoded exactly as presented on cfg_mode.
    typedef enum logic [1:0] {
        MODE_CONST   = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_ALT     = 2'd2,
        MODE_IMPULSE = 2'd3
    } mode_e;

    // Frame sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [7:0]  FP32_BIAS = 8'd127;

endpackage : dft_stim_pkg
`default_nettype wire

// File: rtl/int_to_fp32.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp32
// Description : Combinational exact conversion of an unsigned IW-bit integer
//               plus a sign flag to IEEE-754 single precision. IW <= 24, so
//               no rounding is ever needed.
// Ports       : i_value - unsigned magnitude
//               i_sign  - requested sign (ignored for zero, so -0 never occurs)
//               o_fp    - FP32 encoding
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_fp32
    import dft_stim_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic [IW-1:0] i_value,
    input  logic          i_sign,
    output logic [31:0]   o_fp
);

    logic [4:0]  w_msb;
    logic [23:0] w_ext;
    logic [22:0] w_mant;

    // Priority encoder: the highest set bit wins because it is visited last.
    always_comb begin
        w_msb = 5'd0;
        for (int k = 0; k < IW; k++) begin
            if (i_value[k]) begin
                w_msb = 5'(k);
            end
        end
    end

    assign w_ext = 24'(i_value);

    // Shifting the MSB up to bit 23 and dropping it leaves the fraction
    // bits left-aligned in the 23-bit mantissa field.
    assign w_mant = 23'(w_ext << (5'd23 - w_msb));

    assign o_fp = (i_value == '0) ? FP32_ZERO
                                  : {i_sign, FP32_BIAS + {3'b000, w_msb}, w_mant};

endmodule : int_to_fp32
`default_nettype wire

// File: rtl/dft_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module      : dft_stimulus_gen
// Description : Streams one frame of N_POINTS FP32 test samples per start
//               request, built from a selectable pattern and an integer
//               amplitude, over a valid/ready interface.
// Ports       : clk, rst (async, active-high)
//               start, cfg_mode, cfg_value         - frame request/config
//               out_data, out_valid, out_ready,
//               out_index, out_last                - sample stream
//               busy, done                         - status
// Revision    : 1.0 - initial release
// ============================================================================
module dft_stimulus_gen
    import dft_stim_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int IW       = 8,
    parameter int IDXW     = $clog2(N_POINTS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      cfg_mode,
    input  logic [IW-1:0]   cfg_value,
    output logic [31:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_index,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(N_POINTS - 1);

    state_e          r_state;
    mode_e           r_mode;
    logic [IW-1:0]   r_c;

    logic            w_idle;
    mode_e           w_sel_mode;
    logic [IW-1:0]   w_sel_c;
    logic [IDXW-1:0] w_next_idx;
    logic [IW-1:0]   w_idx_iw;
    logic [IW-1:0]   w_v;
    logic            w_sign;
    logic [31:0]     w_fp;
    logic            w_transfer;

    // In IDLE the sample being prepared is index 0 of a frame that is only
    // now being requested, so the live config inputs are used; in RUN the
    // latched copies are used. out_index doubles as the frame counter.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_sel_mode = w_idle ? mode_e'(cfg_mode) : r_mode;
    assign w_sel_c    = w_idle ? cfg_value : r_c;
    assign w_next_idx = w_idle ? '0 : out_index + IDXW'(1);
    assign w_idx_iw   = IW'(w_next_idx);
    assign w_transfer = out_valid && out_ready;

    always_comb begin
        w_v    = w_sel_c;
        w_sign = 1'b0;
        case (w_sel_mode)
            MODE_CONST:   w_v = w_sel_c;
            MODE_RAMP:    w_v = w_sel_c + w_idx_iw;
            MODE_ALT:     w_sign = w_next_idx[0];
            MODE_IMPULSE: w_v = (w_next_idx == '0) ? w_sel_c : '0;
            default:      w_v = w_sel_c;
        endcase
    end

    int_to_fp32 #(
        .IW (IW)
    ) u_conv (
        .i_value (w_v),
        .i_sign  (w_sign),
        .o_fp    (w_fp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_CONST;
            r_c       <= '0;
            out_data  <= FP32_ZERO;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_mode    <= mode_e'(cfg_mode);
                        r_c       <= cfg_value;
                        out_data  <= w_fp;
                        out_valid <= 1'b1;
                        out_index <= w_next_idx;
                        out_last  <= (w_next_idx == C_LAST_IDX);
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_transfer) begin
                        if (out_index == C_LAST_IDX) begin
                            r_state   <= ST_IDLE;
                            out_data  <= FP32_ZERO;
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_data  <= w_fp;
                            out_index <= w_next_idx;
                            out_last  <= (w_next_idx == C_LAST_IDX);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : dft_stimulus_gen
`default_nettype wire

// File: tb/tb_dft_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dft_stimulus_gen
// Description : Directed self-checking bench for dft_stimulus_gen. A second
//               instance with IW=4 exercises ramp wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dft_stimulus_gen;

    localparam logic [1:0] C_CONST   = 2'd0;
    localparam logic [1:0] C_RAMP    = 2'd1;
    localparam logic [1:0] C_ALT     = 2'd2;
    localparam logic [1:0] C_IMPULSE = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_value;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        start4;
    logic [1:0]  cfg_mode4;
    logic [3:0]  cfg_value4;
    logic [31:0] out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  out_index4;
    logic        out_last4;
    logic        busy4;
    logic        done4;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ramp_exp  [16];
    logic [31:0] alt6_exp  [16];
    logic [31:0] zero_exp  [16];
    logic [31:0] imp1_exp  [16];
    logic [31:0] c255_exp  [16];

    always #5 clk = ~clk;

    dft_stimulus_gen #(.N_POINTS(16), .IW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_mode  (cfg_mode),
        .cfg_value (cfg_value),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    dft_stimulus_gen #(.N_POINTS(16), .IW(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .cfg_mode  (cfg_mode4),
        .cfg_value (cfg_value4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_index (out_index4),
        .out_last  (out_last4),
        .busy      (busy4),
        .done      (done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the IW=8 instance. With chained=1 the start for this
    // frame was already raised by the previous call during its done cycle.
    // A start pulse with different config is injected mid-frame and must be
    // ignored. With chain_next=1, start for the next frame is raised in the
    // done cycle.
    task automatic run_frame(input logic [1:0] mode, input logic [7:0] c,
                             input logic [31:0] exp [16],
                             input int stall_idx, input int stall_n,
                             input bit chained, input bit chain_next,
                             input logic [1:0] next_mode, input logic [7:0] next_c);
        int n;
        int cyc;
        bit stalled;
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        out_ready = 1'b1;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1;
            cfg_mode = mode;
            cfg_value = c;
        end
        @(negedge clk);
        start = 1'b0;
        check("first_valid", {31'b0, out_valid}, 32'd1);
        check("busy_run", {31'b0, busy}, 32'd1);
        check("done_low", {31'b0, done}, 32'd0);
        while (n < 16 && cyc < 200) begin
            start = 1'b0;
            cfg_mode = mode;
            cfg_value = c;
            if (!stalled && stall_n > 0 && out_valid && out_index == 4'(stall_idx)) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    cyc++;
                    check("bp_data", out_data, exp[stall_idx]);
                    check("bp_index", {28'b0, out_index}, 32'(stall_idx));
                end
                out_ready = 1'b1;
            end
            check("data", out_data, exp[n]);
            check("index", {28'b0, out_index}, 32'(n));
            check("last", {31'b0, out_last}, (n == 15) ? 32'd1 : 32'd0);
            if (n == 8) begin
                start = 1'b1;
                cfg_mode = mode ^ 2'd1;
                cfg_value = ~c;
            end
            n++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("beats", 32'(n), 32'd16);
        check("frame_cycles", 32'(cyc), 32'(16 + stall_n));
        check("done_pulse", {31'b0, done}, 32'd1);
        check("valid_after", {31'b0, out_valid}, 32'd0);
        check("busy_after", {31'b0, busy}, 32'd0);
        if (chain_next) begin
            start = 1'b1;
            cfg_mode = next_mode;
            cfg_value = next_c;
        end
    endtask

    initial begin
        int g;
        ramp_exp = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                     32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
                     32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
                     32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000};
        for (int i = 0; i < 16; i++) begin
            alt6_exp[i] = (i % 2 == 1) ? 32'hC0C0_0000 : 32'h40C0_0000;
            zero_exp[i] = 32'h0000_0000;
            imp1_exp[i] = (i == 0) ? 32'h3F80_0000 : 32'h0000_0000;
            c255_exp[i] = 32'h437F_0000;
        end

        rst = 1'b1;
        start = 1'b0;
        cfg_mode = 2'd0;
        cfg_value = 8'd0;
        out_ready = 1'b1;
        start4 = 1'b0;
        cfg_mode4 = 2'd0;
        cfg_value4 = 4'd0;
        out_ready4 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_data", out_data, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_index", {28'b0, out_index}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        run_frame(C_RAMP, 8'd0, ramp_exp, 0, 0, 1'b0, 1'b0, 2'd0, 8'd0);
        run_frame(C_ALT, 8'd6, alt6_exp, 0, 0, 1'b0, 1'b0, 2'd0, 8'd0);
        run_frame(C_ALT, 8'd0, zero_exp, 0, 0, 1'b0, 1'b0, 2'd0, 8'd0);
        run_frame(C_IMPULSE, 8'd1, imp1_exp, 0, 0, 1'b0, 1'b0, 2'd0, 8'd0);
        // Start in the done cycle, then a backpressured ramp frame.
        run_frame(C_CONST, 8'd255, c255_exp, 0, 0, 1'b0, 1'b1, C_RAMP, 8'd0);
        run_frame(C_RAMP, 8'd0, ramp_exp, 5, 3, 1'b1, 1'b0, 2'd0, 8'd0);

        // Reset in the middle of a frame.
        @(negedge clk);
        start = 1'b1;
        cfg_mode = C_RAMP;
        cfg_value = 8'd0;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (out_index != 4'd7 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rst_reach7", {28'b0, out_index}, 32'd7);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_index", {28'b0, out_index}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("arst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_no_restart", {31'b0, out_valid}, 32'd0);
        check("arst_no_done", {31'b0, done}, 32'd0);
        run_frame(C_RAMP, 8'd0, ramp_exp, 0, 0, 1'b0, 1'b0, 2'd0, 8'd0);

        // IW=4 ramp wrap: 15, then (15+1) mod 16 = 0.
        @(negedge clk);
        start4 = 1'b1;
        cfg_mode4 = C_RAMP;
        cfg_value4 = 4'd15;
        @(negedge clk);
        start4 = 1'b0;
        check("wrap_i0_data", out_data4, 32'h4170_0000);
        check("wrap_i0_index", {28'b0, out_index4}, 32'd0);
        @(negedge clk);
        check("wrap_i1_data", out_data4, 32'h0000_0000);
        check("wrap_i1_index", {28'b0, out_index4}, 32'd1);
        @(negedge clk);
        check("wrap_i2_data", out_data4, 32'h3F80_0000);
        g = 0;
        while (!done4 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("wrap_done", {31'b0, done4}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dft_stimulus_gen
`default_nettype wire
